param_seq_fsm: RTL and testbench

Parametrised N-state sequencer FSM driven by a 3-bit user command. It supports forward, backward, jump and soft-clear transitions, with explicit recovery from illegal state encodings. It is the generalised successor to the fixed 4-state cycling FSM and feeds a Moore-style state index to downstream control logic. It also provides wrap and error flags for monitoring.

---
 rtl/param_seq_fsm.sv | 116 +++++++++++
 tb/tb_param_seq_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/param_seq_fsm.sv
// rtl/param_seq_fsm.sv - parametrised N-state sequencer with fwd/back/jump/clear commands
// Optional macro SEQ_LOCK_EN: lock=1 restricts commands to HOLD and FWD.
module param_seq_fsm #(
  parameter int NUM_STATES = 6,
  parameter int STATE_W    = 4,
  parameter int OUT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         user_input,
  input  logic [STATE_W-1:0] jump_idx,
  input  logic               lock,
  output logic [OUT_W-1:0]   out,
  output logic               wrap,
  output logic               cmd_err,
  output logic               illegal_err
);

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'b000,
    CMD_FWD   = 3'b001,
    CMD_BACK  = 3'b010,
    CMD_JUMP  = 3'b011,
    CMD_CLEAR = 3'b100
  } cmd_e;

  localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W:0]   NUM_EXT  = (STATE_W + 1)'(NUM_STATES);

  logic [STATE_W-1:0] r_state;
  logic               r_wrap;
  logic               r_cmd_err;
  logic               r_illegal;

  cmd_e w_cmd;
  logic w_bad_state;
  logic w_jump_ok;
  logic w_locked;

  assign w_cmd       = cmd_e'(user_input);
  assign w_bad_state = ({1'b0, r_state} >= NUM_EXT);
  assign w_jump_ok   = ({1'b0, jump_idx} < NUM_EXT);

`ifdef SEQ_LOCK_EN
  assign w_locked = lock;
`else
  logic w_unused_lock;
  assign w_unused_lock = lock;
  assign w_locked      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= '0;
      r_wrap    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_wrap    <= 1'b0;
      r_cmd_err <= 1'b0;
      // Corrupted encodings recover to 0 ahead of any command, lock included.
      if (w_bad_state) begin
        r_state   <= '0;
        r_illegal <= 1'b1;
      end else if (en) begin
        case (w_cmd)
          CMD_HOLD: begin
            r_state <= r_state;
          end
          CMD_FWD: begin
            if (r_state == LAST_IDX) begin
              r_state <= '0;
              r_wrap  <= 1'b1;
            end else begin
              r_state <= r_state + 1'b1;
            end
          end
          CMD_BACK: begin
            if (w_locked) begin
              r_cmd_err <= 1'b1;
            end else if (r_state == '0) begin
              r_state <= LAST_IDX;
              r_wrap  <= 1'b1;
            end else begin
              r_state <= r_state - 1'b1;
            end
          end
          CMD_JUMP: begin
            if (w_locked || !w_jump_ok) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_state <= jump_idx;
            end
          end
          CMD_CLEAR: begin
            if (w_locked) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_state <= '0;
            end
          end
          default: begin
            r_cmd_err <= 1'b1;
          end
        endcase
      end
    end
  end

  assign out         = OUT_W'(r_state);
  assign wrap        = r_wrap;
  assign cmd_err     = r_cmd_err;
  assign illegal_err = r_illegal;

endmodule

// File: tb/tb_param_seq_fsm.sv
// tb/tb_param_seq_fsm.sv - vector table and scoreboard bench for param_seq_fsm
module tb_param_seq_fsm;

`ifdef SEQ_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] user_input = 3'b000;
  logic [3:0] jump_idx = 4'd0;
  logic       lock = 1'b0;
  logic [3:0] out;
  logic       wrap;
  logic       cmd_err;
  logic       illegal_err;

  param_seq_fsm #(.NUM_STATES(6), .STATE_W(4), .OUT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .user_input(user_input),
    .jump_idx(jump_idx), .lock(lock), .out(out), .wrap(wrap),
    .cmd_err(cmd_err), .illegal_err(illegal_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic       e;
    logic [2:0] c;
    logic [3:0] j;
    logic       l;
    logic [3:0] o;
    logic       w;
    logic       ce;
    logic       ie;
  } vec_t;

  typedef struct packed {
    logic [3:0] o;
    logic       w;
    logic       ce;
    logic       ie;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic e, logic [2:0] c, logic [3:0] j, logic l,
                              logic [3:0] o, logic w, logic ce, logic ie);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.j = j; v.l = l;
    v.o = o; v.w = w; v.ce = ce; v.ie = ie;
    return v;
  endfunction

  task automatic drive(vec_t v);
    exp_t x;
    rst = v.r; en = v.e; user_input = v.c; jump_idx = v.j; lock = v.l;
    x.o = v.o; x.w = v.w; x.ce = v.ce; x.ie = v.ie;
    sb.push_back(x);
  endtask

  task automatic collect(string name);
    exp_t x;
    exp_t a;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      x = sb.pop_front();
      a = {out, wrap, cmd_err, illegal_err};
      if (a !== x) begin
        errors++;
        $display("FAIL %s got out=%0d wrap=%0b cmd_err=%0b illegal_err=%0b want out=%0d wrap=%0b cmd_err=%0b illegal_err=%0b",
                 name, a.o, a.w, a.ce, a.ie, x.o, x.w, x.ce, x.ie);
      end
    end
  endtask

  task automatic apply(vec_t v, string name);
    @(negedge clk);
    drive(v);
    collect(name);
  endtask

  initial begin
    // reset x2, FWD sweep with wrap, BACK wrap, jump bounds, reserved codes, en=0
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'b010, 0, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'b010, 0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b011, 3, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b011, 7, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3'b000, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b010, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b110, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 3'b001, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b100, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b101, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3'b111, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3'b011, 5, 0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b011, 6, 0, 5, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'b010, 0, 0, 0, 0, 0, 0));
    // lock behaviour depends on the build
    tbl.push_back(mk(0, 1, 3'b011, 4, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b011, 1, 1, LOCK_ON ? 4'd4 : 4'd1, 0, LOCK_ON, 0));
    tbl.push_back(mk(0, 1, 3'b100, 0, 1, LOCK_ON ? 4'd4 : 4'd0, 0, LOCK_ON, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 1, LOCK_ON ? 4'd5 : 4'd1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, LOCK_ON ? 4'd5 : 4'd0, 0, LOCK_ON, 0));
    tbl.push_back(mk(0, 1, 3'b000, 0, 1, LOCK_ON ? 4'd5 : 4'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b011, 5, 0, 5, 0, 0, 0));
    // reset beats a wrapping FWD
    tbl.push_back(mk(1, 1, 3'b001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Upset the state register to 9 while a bad jump is requested.
    @(negedge clk);
    drive(mk(0, 1, 3'b011, 7, 0, 0, 0, 0, 1));
    force dut.r_state = 4'd9;
    #1;
    release dut.r_state;
    checks++;
    if (out !== 4'd9) begin
      errors++;
      $display("FAIL fault_inject got out=%0d want 9", out);
    end
    collect("illegal_recover");
    apply(mk(0, 1, 3'b001, 0, 0, 1, 0, 0, 1), "illegal_sticky_fwd");
    apply(mk(0, 1, 3'b010, 0, 0, 0, 0, 0, 1), "illegal_sticky_back");
    apply(mk(0, 1, 3'b010, 0, 0, 5, 1, 0, 1), "illegal_sticky_wrap");
    apply(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0), "illegal_cleared_by_rst");
    apply(mk(0, 1, 3'b001, 0, 0, 1, 0, 0, 0), "after_rst_fwd");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
